// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the fetch-stage PC sequencer and any program_counter
// users: the sequencer state encoding and the PC select codes.
// -----------------------------------------------------------------------------
package pc_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_REDIRECT = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_STALL    = 3'd3,
    ST_HALT     = 3'd4
  } pc_seq_state_e;

  // PC select codes understood by program_counter
  localparam logic [6:0] PC_SEL_JUMP = 7'h00;
  localparam logic [6:0] PC_SEL_INC  = 7'h01;
  localparam logic [6:0] PC_SEL_HOLD = 7'h7F;

  // Width of the flush down-counter (FLUSH_CYCLES is limited to 1..7)
  localparam int FLUSH_W = 3;

endpackage : pc_seq_pkg

// File: rtl/pc_seq_perf.sv
// -----------------------------------------------------------------------------
// pc_seq_perf
// Two free-running performance counters that wrap modulo 2^CNT_W.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_redirect_inc      : count one redirect this edge
//   i_stall_inc         : count one stall cycle this edge
//   o_redirect_cnt      : redirects issued
//   o_stall_cyc_cnt     : cycles spent stalled
// -----------------------------------------------------------------------------
module pc_seq_perf #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_redirect_inc,
  input  logic             i_stall_inc,
  output logic [CNT_W-1:0] o_redirect_cnt,
  output logic [CNT_W-1:0] o_stall_cyc_cnt
);

  logic [CNT_W-1:0] r_redirect_cnt;
  logic [CNT_W-1:0] r_stall_cyc_cnt;

  // Wrapping counters; overflow rolls back to zero by design
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_redirect_cnt  <= '0;
      r_stall_cyc_cnt <= '0;
    end else begin
      if (i_redirect_inc) begin
        r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
      end
      if (i_stall_inc) begin
        r_stall_cyc_cnt <= r_stall_cyc_cnt + CNT_W'(1);
      end
    end
  end

  assign o_redirect_cnt  = r_redirect_cnt;
  assign o_stall_cyc_cnt = r_stall_cyc_cnt;

endmodule : pc_seq_perf

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Drives the fetch-stage PC select code and jump target from branch redirects,
// load-use stalls and halt/resume events. All outputs are registered: an event
// sampled at edge N is visible after edge N and acted on by the PC at edge N+1.
// Ports:
//   i_clk, i_rst                : clock, synchronous active-high reset
//   i_branch_valid/_target      : taken branch and its target
//   i_stall_req, i_stall_len    : load-use hold request and length (0 -> 1)
//   i_halt_req, i_resume        : halt decode and external restart
//   o_pc_scr                    : 00 load jump, 01 increment, 7F hold
//   o_jump_add                  : redirect target
//   o_flush_if                  : squash IF/ID (REDIRECT and FLUSH)
//   o_halted                    : core halted
//   o_redirect_cnt, o_stall_cyc_cnt : wrapping performance counters
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W       = 7,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_W      = 3,
  parameter int CNT_W        = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_branch_valid,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_stall_req,
  input  logic [STALL_W-1:0] i_stall_len,
  input  logic              i_halt_req,
  input  logic              i_resume,
  output logic [6:0]        o_pc_scr,
  output logic [ADDR_W-1:0] o_jump_add,
  output logic              o_flush_if,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_redirect_cnt,
  output logic [CNT_W-1:0]  o_stall_cyc_cnt
);

  pc_seq_state_e      r_state;
  pc_seq_state_e      w_state_nxt;
  logic [FLUSH_W-1:0] r_flush_cnt;
  logic [FLUSH_W-1:0] w_flush_cnt_nxt;
  logic [STALL_W-1:0] r_stall_cnt;
  logic [STALL_W-1:0] w_stall_cnt_nxt;
  logic               r_halt_pending;
  logic               w_halt_pending_nxt;
  logic               w_take_branch;
  logic [STALL_W-1:0] w_stall_load;

  logic [6:0]         r_pc_scr;
  logic [6:0]         w_pc_scr_nxt;
  logic [ADDR_W-1:0]  r_jump_add;
  logic [ADDR_W-1:0]  w_jump_add_nxt;
  logic               r_flush_if;
  logic               w_flush_if_nxt;
  logic               r_halted;
  logic               w_halted_nxt;

  // A zero-length stall still holds the PC for one cycle
  assign w_stall_load = (i_stall_len == '0) ? STALL_W'(1) : i_stall_len;

  // Next-state logic; in REDIRECT/FLUSH branch and stall requests belong to
  // squashed instructions, so only halt is remembered (as halt_pending)
  always_comb begin
    w_state_nxt        = r_state;
    w_flush_cnt_nxt    = r_flush_cnt;
    w_stall_cnt_nxt    = r_stall_cnt;
    w_halt_pending_nxt = r_halt_pending;
    w_take_branch      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_branch_valid) begin
          w_state_nxt   = ST_REDIRECT;
          w_take_branch = 1'b1;
        end else if (i_halt_req) begin
          w_state_nxt = ST_HALT;
        end else if (i_stall_req) begin
          w_state_nxt     = ST_STALL;
          w_stall_cnt_nxt = w_stall_load;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        w_state_nxt     = ST_FLUSH;
        w_flush_cnt_nxt = FLUSH_W'(FLUSH_CYCLES);
        if (i_halt_req) begin
          w_halt_pending_nxt = 1'b1;
        end else begin
          w_halt_pending_nxt = r_halt_pending;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt <= FLUSH_W'(1)) begin
          // A halt seen on the final flush cycle is honoured as well
          if (r_halt_pending || i_halt_req) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_state_nxt = ST_RUN;
          end
          w_flush_cnt_nxt    = '0;
          w_halt_pending_nxt = 1'b0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FLUSH_W'(1);
          if (i_halt_req) begin
            w_halt_pending_nxt = 1'b1;
          end else begin
            w_halt_pending_nxt = r_halt_pending;
          end
        end
      end
      ST_STALL: begin
        if (i_branch_valid) begin
          w_state_nxt     = ST_REDIRECT;
          w_take_branch   = 1'b1;
          w_stall_cnt_nxt = '0;
        end else if (i_halt_req) begin
          w_state_nxt     = ST_HALT;
          w_stall_cnt_nxt = '0;
        end else if (r_stall_cnt <= STALL_W'(1)) begin
          w_state_nxt     = ST_RUN;
          w_stall_cnt_nxt = '0;
        end else begin
          w_stall_cnt_nxt = r_stall_cnt - STALL_W'(1);
        end
      end
      ST_HALT: begin
        if (i_resume && !i_halt_req) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_HALT;
        end
      end
      default: begin
        w_state_nxt        = ST_RUN;
        w_flush_cnt_nxt    = '0;
        w_stall_cnt_nxt    = '0;
        w_halt_pending_nxt = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so outputs can be registered
  always_comb begin
    w_pc_scr_nxt   = PC_SEL_INC;
    w_flush_if_nxt = 1'b0;
    w_halted_nxt   = 1'b0;
    case (w_state_nxt)
      ST_RUN: begin
        w_pc_scr_nxt = PC_SEL_INC;
      end
      ST_REDIRECT: begin
        w_pc_scr_nxt   = PC_SEL_JUMP;
        w_flush_if_nxt = 1'b1;
      end
      ST_FLUSH: begin
        w_pc_scr_nxt   = PC_SEL_INC;
        w_flush_if_nxt = 1'b1;
      end
      ST_STALL: begin
        w_pc_scr_nxt = PC_SEL_HOLD;
      end
      ST_HALT: begin
        w_pc_scr_nxt = PC_SEL_HOLD;
        w_halted_nxt = 1'b1;
      end
      default: begin
        w_pc_scr_nxt = PC_SEL_INC;
      end
    endcase
    if (w_take_branch) begin
      w_jump_add_nxt = i_branch_target;
    end else begin
      w_jump_add_nxt = r_jump_add;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_RUN;
      r_flush_cnt    <= '0;
      r_stall_cnt    <= '0;
      r_halt_pending <= 1'b0;
      r_pc_scr       <= PC_SEL_INC;
      r_jump_add     <= '0;
      r_flush_if     <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_flush_cnt    <= w_flush_cnt_nxt;
      r_stall_cnt    <= w_stall_cnt_nxt;
      r_halt_pending <= w_halt_pending_nxt;
      r_pc_scr       <= w_pc_scr_nxt;
      r_jump_add     <= w_jump_add_nxt;
      r_flush_if     <= w_flush_if_nxt;
      r_halted       <= w_halted_nxt;
    end
  end

  pc_seq_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_redirect_inc  (w_take_branch),
    .i_stall_inc     (r_state == ST_STALL),
    .o_redirect_cnt  (o_redirect_cnt),
    .o_stall_cyc_cnt (o_stall_cyc_cnt)
  );

  assign o_pc_scr   = r_pc_scr;
  assign o_jump_add = r_jump_add;
  assign o_flush_if = r_flush_if;
  assign o_halted   = r_halted;

endmodule : pc_sequencer
